// File: rtl/jt053247_draw.sv
// Sprite tile-row drawer behind the 053246 scanner: fetches one 16-pixel tile row,
// applies horizontal zoom/flip and writes opaque pixels to the object line buffer.
// Optional: define JT053247_CLIP_EN to suppress writes outside columns 0x020..0x19F.
module jt053247_draw #(
    parameter int unsigned ZW = 12,
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          dr_start,
    output logic          dr_busy,
    input  logic [15:0]   code,
    input  logic [9:0]    attr,
    input  logic [1:0]    shd,
    input  logic          hflip,
    input  logic          vflip,
    input  logic [8:0]    hpos,
    input  logic [3:0]    ysub,
    input  logic [ZW-1:0] hzoom,
    input  logic          hz_keep,
    output logic [20:0]   rom_addr,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [31:0]   rom_data,
    output logic [AW-1:0] buf_addr,
    output logic [15:0]   buf_din,
    output logic          buf_we
);

    localparam int unsigned ACCW = 13;
    localparam logic [ACCW-1:0] ACC_END = ACCW'(1024);

    typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_e;

    state_e          state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [AW-1:0]   col_q, col_d;
    logic [15:0]     code_q, code_d;
    logic [9:0]      attr_q, attr_d;
    logic [1:0]      shd_q, shd_d;
    logic            hflip_q, hflip_d;
    logic [3:0]      row_q, row_d;
    logic [ZW-1:0]   hzoom_q, hzoom_d;
    logic [31:0]     data_q, data_d;
    logic            half_q, half_d;
    logic            busy_q, busy_d;
    logic            rom_cs_q, rom_cs_d;
    logic [20:0]     rom_addr_q, rom_addr_d;
    logic            buf_we_q, buf_we_d;
    logic [AW-1:0]   buf_addr_q, buf_addr_d;
    logic [15:0]     buf_din_q, buf_din_d;

    logic            accept;
    logic [3:0]      src;
    logic            hit;
    logic [31:0]     data_sh;
    logic [3:0]      pix;
    logic [ACCW-1:0] acc_nx;
    logic            done;
    logic [ACCW-1:0] acc_keep;
    logic            vis;

    assign accept   = (state_q == IDLE) && !busy_q && dr_start;
    assign src      = acc_q[9:6] ^ {4{hflip_q}};
    assign hit      = (src[3] == half_q);
    assign data_sh  = data_q << {src[2:0], 2'b00};
    assign pix      = data_sh[31:28];
    assign acc_nx   = acc_q + ACCW'(hzoom_q);
    assign done     = (acc_nx >= ACC_END);
    // Residual fraction carried into a continued tile
    assign acc_keep = (acc_q >= ACC_END) ? (acc_q - ACC_END) : acc_q;

`ifdef JT053247_CLIP_EN
    assign vis = (col_q >= AW'(32)) && (col_q <= AW'(415));
`else
    assign vis = 1'b1;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            col_q      <= '0;
            code_q     <= '0;
            attr_q     <= '0;
            shd_q      <= '0;
            hflip_q    <= 1'b0;
            row_q      <= '0;
            hzoom_q    <= '0;
            data_q     <= '0;
            half_q     <= 1'b0;
            busy_q     <= 1'b0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            col_q      <= col_d;
            code_q     <= code_d;
            attr_q     <= attr_d;
            shd_q      <= shd_d;
            hflip_q    <= hflip_d;
            row_q      <= row_d;
            hzoom_q    <= hzoom_d;
            data_q     <= data_d;
            half_q     <= half_d;
            busy_q     <= busy_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_din_q  <= buf_din_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (hzoom != '0)) state_d = FETCH;
            FETCH:   if (rom_ok) state_d = DRAW;
            DRAW: begin
                if (!hit)      state_d = FETCH;
                else if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        acc_d      = acc_q;
        col_d      = col_q;
        code_d     = code_q;
        attr_d     = attr_q;
        shd_d      = shd_q;
        hflip_d    = hflip_q;
        row_d      = row_q;
        hzoom_d    = hzoom_q;
        data_d     = data_q;
        half_d     = half_q;
        rom_addr_d = rom_addr_q;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_din_d  = buf_din_q;

        if (accept) begin
            code_d  = code;
            attr_d  = attr;
            shd_d   = shd;
            hflip_d = hflip;
            row_d   = ysub ^ {4{vflip}};
            hzoom_d = hzoom;
            if (hz_keep) begin
                acc_d = acc_keep;
            end else begin
                acc_d = '0;
                col_d = AW'(hpos);
            end
        end

        if ((state_q == FETCH) && rom_ok) begin
            data_d = rom_data;
            half_d = rom_addr_q[0];
        end

        if ((state_q == DRAW) && hit) begin
            buf_we_d   = (pix != 4'd0) && vis;
            buf_addr_d = col_q;
            buf_din_d  = {shd_q, attr_q, pix};
            col_d      = col_q + AW'(1);
            acc_d      = acc_nx;
        end

        // Half select is src[3] of the next pixel to draw
        if (state_d == FETCH) rom_addr_d = {code_d, row_d, acc_d[9] ^ hflip_d};

        rom_cs_d = (state_d == FETCH);
        busy_d   = (state_d != IDLE) || (accept && (hzoom == '0));
    end

    assign dr_busy  = busy_q;
    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign buf_we   = buf_we_q;
    assign buf_addr = buf_addr_q;
    assign buf_din  = buf_din_q;

endmodule

// File: tb/tb_jt053247_draw.sv
// Directed bench for jt053247_draw: ROM responder with programmable latency,
// line-buffer write capture and per-tile comparison against hand-built expectations.
module tb_jt053247_draw;

    localparam int unsigned ZW = 12;
    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          dr_start = 1'b0;
    logic          dr_busy;
    logic [15:0]   code = '0;
    logic [9:0]    attr = '0;
    logic [1:0]    shd = '0;
    logic          hflip = 1'b0;
    logic          vflip = 1'b0;
    logic [8:0]    hpos = '0;
    logic [3:0]    ysub = '0;
    logic [ZW-1:0] hzoom = '0;
    logic          hz_keep = 1'b0;
    logic [20:0]   rom_addr;
    logic          rom_cs;
    logic          rom_ok = 1'b0;
    logic [31:0]   rom_data = '0;
    logic [AW-1:0] buf_addr;
    logic [15:0]   buf_din;
    logic          buf_we;

    jt053247_draw #(.ZW(ZW), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .dr_start(dr_start), .dr_busy(dr_busy),
        .code(code), .attr(attr), .shd(shd), .hflip(hflip), .vflip(vflip),
        .hpos(hpos), .ysub(ysub), .hzoom(hzoom), .hz_keep(hz_keep),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ROM_H0 = 32'h12345678;
    localparam logic [31:0] ROM_H1 = 32'h9ABCDEF0;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          cyc = 0;
    int          t_start = 0;
    int          first_wr = -1;
    int          rom_lat = 1;
    int          rom_cnt = 0;
    int          rom_unstable = 0;
    logic [20:0] rom_hold = '0;
    logic [31:0] wq[$];
    logic [31:0] eq[$];
    logic [31:0] fq[$];
    logic [31:0] efq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wr(input int col, input logic [1:0] s,
                                       input logic [9:0] a, input logic [3:0] p);
        return {7'd0, 9'(col), s, a, p};
    endfunction

    function automatic logic [31:0] fa(input logic [15:0] c, input logic [3:0] r, input logic h);
        return {11'd0, c, r, h};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ROM responder: rom_ok rom_lat cycles after rom_cs, one cycle wide
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            rom_ok  = 1'b0;
            rom_cnt = 0;
        end else if (rom_ok) begin
            rom_ok  = 1'b0;
            rom_cnt = 0;
        end else if (rom_cs) begin
            if (rom_cnt == 0) rom_hold = rom_addr;
            else if (rom_addr !== rom_hold) rom_unstable++;
            if (rom_cnt == rom_lat) begin
                rom_ok   = 1'b1;
                rom_data = rom_addr[0] ? ROM_H1 : ROM_H0;
                fq.push_back(32'(rom_addr));
            end else begin
                rom_cnt++;
            end
        end
    end

    // Line-buffer write capture
    initial forever begin
        @(negedge clk);
        if (buf_we === 1'b1) begin
            wq.push_back({7'd0, buf_addr, buf_din});
            if (first_wr < 0) first_wr = cyc;
        end
    end

    task automatic start_tile(input logic [15:0] c, input logic [9:0] a, input logic [1:0] s,
                              input logic hf, input logic vf, input logic [8:0] hp,
                              input logic [3:0] ys, input logic [ZW-1:0] hz, input logic keep);
        @(negedge clk);
        wq.delete();
        fq.delete();
        eq.delete();
        efq.delete();
        first_wr = -1;
        code = c; attr = a; shd = s; hflip = hf; vflip = vf;
        hpos = hp; ysub = ys; hzoom = hz; hz_keep = keep;
        dr_start = 1'b1;
        t_start  = cyc;
        @(negedge clk);
        dr_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dr_busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_timeout"}, 32'(n < 300), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic cmp_run(input string tag);
        int nw;
        int nf;
        check({tag, "_nwrites"}, 32'(wq.size()), 32'(eq.size()));
        nw = (wq.size() < eq.size()) ? wq.size() : eq.size();
        for (int i = 0; i < nw; i++) check($sformatf("%s_wr%0d", tag, i), wq[i], eq[i]);
        check({tag, "_nfetch"}, 32'(fq.size()), 32'(efq.size()));
        nf = (fq.size() < efq.size()) ? fq.size() : efq.size();
        for (int i = 0; i < nf; i++) check($sformatf("%s_fetch%0d", tag, i), fq[i], efq[i]);
    endtask

    initial begin
        int n;
        int held;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(dr_busy), 32'd0);
        check("rst_rom", {10'd0, rom_cs, rom_addr}, 32'd0);
        check("rst_buf", {6'd0, buf_we, buf_addr, buf_din}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Unzoomed, no flip; vflip=1 inverts the row
        start_tile(16'hBEEF, 10'h2A5, 2'b10, 1'b0, 1'b1, 9'h050, 4'h3, 12'h040, 1'b0);
        check("t1_busy_rise", 32'(dr_busy), 32'd1);
        for (int i = 0; i < 15; i++) eq.push_back(wr(16'h50 + i, 2'b10, 10'h2A5, 4'(i + 1)));
        efq.push_back(fa(16'hBEEF, 4'hC, 1'b0));
        efq.push_back(fa(16'hBEEF, 4'hC, 1'b1));
        wait_idle("t1");
        cmp_run("t1");
        check("t1_latency", 32'(first_wr - t_start), 32'd4);

        // Horizontal flip
        start_tile(16'h0123, 10'h0F0, 2'b01, 1'b1, 1'b0, 9'h050, 4'h7, 12'h040, 1'b0);
        for (int i = 1; i < 16; i++) eq.push_back(wr(16'h50 + i, 2'b01, 10'h0F0, 4'(16 - i)));
        efq.push_back(fa(16'h0123, 4'h7, 1'b1));
        efq.push_back(fa(16'h0123, 4'h7, 1'b0));
        wait_idle("t2");
        cmp_run("t2");

        // Half zoom: each source pixel covers two columns
        start_tile(16'h4444, 10'h155, 2'b11, 1'b0, 1'b0, 9'h100, 4'h2, 12'h020, 1'b0);
        for (int k = 0; k < 15; k++) begin
            eq.push_back(wr(16'h100 + 2 * k, 2'b11, 10'h155, 4'(k + 1)));
            eq.push_back(wr(16'h101 + 2 * k, 2'b11, 10'h155, 4'(k + 1)));
        end
        efq.push_back(fa(16'h4444, 4'h2, 1'b0));
        efq.push_back(fa(16'h4444, 4'h2, 1'b1));
        wait_idle("t3a");
        cmp_run("t3a");

        // Continued tile: column carries on from hpos+32, hpos ignored
        start_tile(16'h4445, 10'h155, 2'b11, 1'b0, 1'b0, 9'h000, 4'h2, 12'h040, 1'b1);
        for (int i = 0; i < 15; i++) eq.push_back(wr(16'h120 + i, 2'b11, 10'h155, 4'(i + 1)));
        efq.push_back(fa(16'h4445, 4'h2, 1'b0));
        efq.push_back(fa(16'h4445, 4'h2, 1'b1));
        wait_idle("t3b");
        cmp_run("t3b");

        // Column wrap at the end of the line
        start_tile(16'h0001, 10'h001, 2'b00, 1'b0, 1'b0, 9'h1FC, 4'h0, 12'h040, 1'b0);
`ifndef JT053247_CLIP_EN
        for (int i = 0; i < 15; i++) eq.push_back(wr((16'h1FC + i) & 16'h1FF, 2'b00, 10'h001, 4'(i + 1)));
`endif
        efq.push_back(fa(16'h0001, 4'h0, 1'b0));
        efq.push_back(fa(16'h0001, 4'h0, 1'b1));
        wait_idle("t4");
        cmp_run("t4");

        // Zero zoom: one busy cycle, no fetch, no write
        start_tile(16'h7777, 10'h3FF, 2'b11, 1'b0, 1'b0, 9'h080, 4'h1, 12'h000, 1'b0);
        check("t5_busy_hi", 32'(dr_busy), 32'd1);
        check("t5_no_cs", 32'(rom_cs), 32'd0);
        @(negedge clk);
        check("t5_busy_lo", 32'(dr_busy), 32'd0);
        repeat (4) @(negedge clk);
        cmp_run("t5");

        // Slow ROM plus an ignored dr_start while busy
        rom_lat = 5;
        rom_unstable = 0;
        start_tile(16'hBEEF, 10'h2A5, 2'b10, 1'b0, 1'b1, 9'h050, 4'h3, 12'h040, 1'b0);
        repeat (2) @(negedge clk);
        check("t6_busy_mid", 32'(dr_busy), 32'd1);
        hpos = 9'h070;
        code = 16'h5555;
        dr_start = 1'b1;
        @(negedge clk);
        dr_start = 1'b0;
        check("t6_busy_after", 32'(dr_busy), 32'd1);
        for (int i = 0; i < 15; i++) eq.push_back(wr(16'h50 + i, 2'b10, 10'h2A5, 4'(i + 1)));
        efq.push_back(fa(16'hBEEF, 4'hC, 1'b0));
        efq.push_back(fa(16'hBEEF, 4'hC, 1'b1));
        wait_idle("t6");
        cmp_run("t6");
        check("t6_cs_stable", 32'(rom_unstable), 32'd0);
        rom_lat = 1;

        // Reset during DRAW
        start_tile(16'hBEEF, 10'h2A5, 2'b10, 1'b0, 1'b0, 9'h050, 4'h3, 12'h040, 1'b0);
        n = 0;
        while (wq.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t7_draw_reached", 32'(n < 100), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("t7_rst_busy", 32'(dr_busy), 32'd0);
        check("t7_rst_cs", 32'(rom_cs), 32'd0);
        check("t7_rst_we", 32'(buf_we), 32'd0);
        repeat (2) @(negedge clk);
        held = wq.size();
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("t7_no_late_wr", 32'(wq.size()), 32'(held));
        check("t7_idle", 32'(dr_busy), 32'd0);

        start_tile(16'h0ABC, 10'h111, 2'b01, 1'b0, 1'b0, 9'h060, 4'h9, 12'h040, 1'b0);
        for (int i = 0; i < 15; i++) eq.push_back(wr(16'h60 + i, 2'b01, 10'h111, 4'(i + 1)));
        efq.push_back(fa(16'h0ABC, 4'h9, 1'b0));
        efq.push_back(fa(16'h0ABC, 4'h9, 1'b1));
        wait_idle("t7");
        cmp_run("t7");
        check("t7_latency", 32'(first_wr - t_start), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
